// File: rtl/sdram_arbiter.sv
// Serialises NPORTS requesters onto one SDRAM controller rd/we + ready handshake.
// Define SDRAM_ARB_RR_EN for round-robin selection; fixed priority (lowest index) otherwise.
module sdram_arbiter #(
  parameter int NPORTS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NPORTS-1:0]    p_req,
  input  logic [NPORTS-1:0]    p_we,
  input  logic [NPORTS*27-1:0] p_addr,
  input  logic [NPORTS*16-1:0] p_din,
  input  logic [NPORTS*2-1:0]  p_wtbt,
  output logic [NPORTS-1:0]    p_ack,
  output logic [15:0]          p_dout,
  output logic [26:0]          mem_addr,
  output logic [15:0]          mem_din,
  output logic [1:0]           mem_wtbt,
  output logic                 mem_rd,
  output logic                 mem_we,
  input  logic [15:0]          mem_dout,
  input  logic                 mem_ready
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_HOLD, ST_WAIT, ST_ACK} state_t;

  state_t              state_q;
  logic [IW-1:0]       grant_q;
  logic                we_q;
  logic [NPORTS-1:0]   p_ack_q;
  logic [15:0]         p_dout_q;
  logic [26:0]         mem_addr_q;
  logic [15:0]         mem_din_q;
  logic [1:0]          mem_wtbt_q;
  logic                mem_rd_q;
  logic                mem_we_q;

  logic [IW-1:0]       grant_d;
  logic                grant_vld_d;
  logic [NPORTS-1:0]   grant_oh;

  logic [26:0] addr_a [NPORTS];
  logic [15:0] din_a  [NPORTS];
  logic [1:0]  wtbt_a [NPORTS];

  for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
    assign addr_a[g] = p_addr[g*27 +: 27];
    assign din_a[g]  = p_din[g*16 +: 16];
    assign wtbt_a[g] = p_wtbt[g*2 +: 2];
  end

`ifdef SDRAM_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW:0]   cand;

  // ptr_q holds the first port to consider; it moves to just past each winner.
  always_comb begin
    grant_d     = '0;
    grant_vld_d = 1'b0;
    cand        = '0;
    for (int i = 0; i < NPORTS; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NPORTS)) cand = cand - (IW+1)'(NPORTS);
      if (!grant_vld_d && p_req[cand[IW-1:0]]) begin
        grant_vld_d = 1'b1;
        grant_d     = cand[IW-1:0];
      end
    end
  end

  assign ptr_d = (grant_d == IW'(NPORTS-1)) ? '0 : grant_d + 1'b1;
`else
  always_comb begin
    grant_d     = '0;
    grant_vld_d = 1'b0;
    for (int i = NPORTS-1; i >= 0; i--) begin
      if (p_req[i]) begin
        grant_vld_d = 1'b1;
        grant_d     = IW'(i);
      end
    end
  end
`endif

  assign grant_oh = {{(NPORTS-1){1'b0}}, 1'b1} << grant_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      we_q       <= 1'b0;
      p_ack_q    <= '0;
      p_dout_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_wtbt_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_we_q   <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_ready && grant_vld_d) begin
            grant_q    <= grant_d;
            we_q       <= p_we[grant_d];
            mem_addr_q <= addr_a[grant_d];
            mem_din_q  <= din_a[grant_d];
            mem_wtbt_q <= wtbt_a[grant_d];
            mem_rd_q   <= ~p_we[grant_d];
            mem_we_q   <= p_we[grant_d];
`ifdef SDRAM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_rd_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= ST_HOLD;
        end
        // Controller's ready drop is registered, so ready seen here is stale.
        ST_HOLD: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (mem_ready) begin
            if (!we_q) p_dout_q <= mem_dout;
            p_ack_q <= grant_oh;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          p_ack_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign p_ack    = p_ack_q;
  assign p_dout   = p_dout_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_wtbt = mem_wtbt_q;
  assign mem_rd   = mem_rd_q;
  assign mem_we   = mem_we_q;

endmodule
